mem_load_align: RTL and testbench

- MEM-stage load unit for the MIPS datapath.
- Accepts a load request and issues a word-aligned read to a variable-latency data memory with a req/ready handshake.
- Selects the addressed byte or halfword lane and sign- or zero-extends it to 32 bits.
- Registers the result for the MEM/WB latch and stalls the pipeline while the access is outstanding.

---
 rtl/mem_load_align.sv | 155 +++++++++++++++
 tb/tb_mem_load_align.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_align.sv
// MEM-stage load unit: issues a word-aligned read over a req/ready handshake,
// selects the byte/halfword lane, extends it and stalls the pipe meanwhile.
module mem_load_align #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        LoadReq,
    input  logic [31:0] LoadAddr,
    input  logic [1:0]  LoadSize,
    input  logic        LoadUnsigned,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemReady,
    input  logic [31:0] MemRData,
    output logic [31:0] LoadData,
    output logic        LoadValid,
    output logic        Stall,
    output logic        Misaligned,
    output logic        BusErr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_err_q, bus_err_d;

    logic        misaligned_req;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] lane_data;

    assign misaligned_req = (LoadSize == 2'b11)
                         || (LoadSize == 2'b01 && LoadAddr[0])
                         || (LoadSize == 2'b10 && LoadAddr[1:0] != 2'b00);

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    always_comb begin
        byte_lane = MemRData[7:0];
        unique case (addr_lo_q)
            2'b00: byte_lane = MemRData[31:24];
            2'b01: byte_lane = MemRData[23:16];
            2'b10: byte_lane = MemRData[15:8];
            2'b11: byte_lane = MemRData[7:0];
        endcase
        half_lane = addr_lo_q[1] ? MemRData[15:0] : MemRData[31:16];
        unique case (size_q)
            2'b00:   lane_data = {{24{byte_lane[7] & ~uns_q}}, byte_lane};
            2'b01:   lane_data = {{16{half_lane[15] & ~uns_q}}, half_lane};
            default: lane_data = MemRData;
        endcase
    end

    // NOTE: every _d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        uns_d        = uns_q;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (LoadReq) begin
                    addr_lo_d = LoadAddr[1:0];
                    size_d    = LoadSize;
                    uns_d     = LoadUnsigned;
                    if (misaligned_req) begin
                        state_d      = ERR;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {LoadAddr[31:2], 2'b00};
                    end
                end
            end
            REQ: begin
                if (MemReady) begin
                    load_data_d  = lane_data;
                    load_valid_d = 1'b1;
                    state_d      = DONE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    mem_req_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            addr_lo_q    <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign Stall      = (state_q == REQ) || (state_q == IDLE && LoadReq);
    assign MemReq     = mem_req_q;
    assign MemAddr    = mem_addr_q;
    assign LoadData   = load_data_q;
    assign LoadValid  = load_valid_q;
    assign Misaligned = misaligned_q;
    assign BusErr     = bus_err_q;

endmodule

// File: tb/tb_mem_load_align.sv
// Directed bench for mem_load_align: each task drives one scenario and checks
// its own hand-computed expectations; inputs change and outputs are sampled on negedge.
module tb_mem_load_align;

    localparam int MAX_WAIT = 16;

    logic        Clk;
    logic        Reset;
    logic        LoadReq;
    logic [31:0] LoadAddr;
    logic [1:0]  LoadSize;
    logic        LoadUnsigned;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemReady;
    logic [31:0] MemRData;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        Stall;
    logic        Misaligned;
    logic        BusErr;

    int n_cmp = 0;
    int n_bad = 0;

    int          obs_stall;
    int          obs_req;
    int          obs_valid;
    int          obs_mis;
    int          obs_berr;
    logic [31:0] obs_data;
    logic [31:0] obs_mem_addr;

    mem_load_align #(.MAX_WAIT(MAX_WAIT)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .LoadReq      (LoadReq),
        .LoadAddr     (LoadAddr),
        .LoadSize     (LoadSize),
        .LoadUnsigned (LoadUnsigned),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemReady     (MemReady),
        .MemRData     (MemRData),
        .LoadData     (LoadData),
        .LoadValid    (LoadValid),
        .Stall        (Stall),
        .Misaligned   (Misaligned),
        .BusErr       (BusErr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drives one load starting just after a negedge; memory answers on the lat-th
    // cycle that MemReq is seen high (lat=0 never answers).
    task automatic run_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] rdata,
                            input int lat, input int cycles);
        obs_stall = 0; obs_req = 0; obs_valid = 0; obs_mis = 0; obs_berr = 0;
        obs_data = 'x; obs_mem_addr = 'x;
        LoadAddr = addr; LoadSize = size; LoadUnsigned = uns; MemRData = rdata;
        MemReady = 1'b0; LoadReq = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            #1;
            if (Stall) obs_stall++;
            if (MemReq) begin
                obs_req++;
                obs_mem_addr = MemAddr;
            end
            if (LoadValid) begin
                obs_valid++;
                obs_data = LoadData;
            end
            if (Misaligned) obs_mis++;
            if (BusErr) obs_berr++;
            MemReady = MemReq && (obs_req == lat);
            if (!Stall) LoadReq = 1'b0;
            @(negedge Clk);
        end
        MemReady = 1'b0;
        LoadReq  = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; LoadReq = 1'b0; LoadAddr = '0; LoadSize = '0;
        LoadUnsigned = 1'b0; MemReady = 1'b0; MemRData = '0;
        #2;
        n_cmp++; if (MemReq !== 1'b0) begin n_bad++; $display("FAIL reset_memreq: got %b want 0", MemReq); end
        n_cmp++; if (MemAddr !== 32'h0) begin n_bad++; $display("FAIL reset_memaddr: got %h want 00000000", MemAddr); end
        n_cmp++; if (LoadData !== 32'h0) begin n_bad++; $display("FAIL reset_loaddata: got %h want 00000000", LoadData); end
        n_cmp++; if ({LoadValid, Misaligned, BusErr, Stall} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 0000", {LoadValid, Misaligned, BusErr, Stall}); end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        LoadAddr = 32'h0000_3008; LoadSize = 2'b10; LoadUnsigned = 1'b0;
        MemRData = 32'hCAFE_F00D; LoadReq = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (!Stall) LoadReq = 1'b0;
            @(negedge Clk);
        end
        #1;
        n_cmp++; if (MemReq !== 1'b1) begin n_bad++; $display("FAIL midrst_req_before: got %b want 1", MemReq); end
        #1 Reset = 1'b0;
        #1;
        n_cmp++; if (MemReq !== 1'b0) begin n_bad++; $display("FAIL midrst_req_drop: got %b want 0", MemReq); end
        LoadReq = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        MemReady = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if ({LoadValid, MemReq, Stall, Misaligned, BusErr} !== 5'b0) begin
                n_bad++; $display("FAIL midrst_idle_flags: got %b want 00000", {LoadValid, MemReq, Stall, Misaligned, BusErr}); end
            n_cmp++; if (LoadData !== 32'h0 || MemAddr !== 32'h0) begin
                n_bad++; $display("FAIL midrst_idle_regs: got data %h addr %h want 0 0", LoadData, MemAddr); end
            @(negedge Clk);
        end
        MemReady = 1'b0;
    endtask

    task automatic test_lb();
        run_load(32'h0000_1003, 2'b00, 1'b0, 32'h1234_5680, 1, 6);
        n_cmp++; if (obs_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_data: got %h want ffffff80", obs_data); end
        n_cmp++; if (obs_mem_addr !== 32'h0000_1000) begin n_bad++; $display("FAIL lb_memaddr: got %h want 00001000", obs_mem_addr); end
        n_cmp++; if (obs_valid !== 1) begin n_bad++; $display("FAIL lb_valid_count: got %0d want 1", obs_valid); end
        n_cmp++; if (obs_stall !== 2) begin n_bad++; $display("FAIL lb_stall_cycles: got %0d want 2", obs_stall); end
    endtask

    task automatic test_lbu();
        run_load(32'h0000_1003, 2'b00, 1'b1, 32'h1234_5680, 1, 6);
        n_cmp++; if (obs_data !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_data: got %h want 00000080", obs_data); end
        n_cmp++; if (obs_valid !== 1) begin n_bad++; $display("FAIL lbu_valid_count: got %0d want 1", obs_valid); end
    endtask

    task automatic test_lh_slow();
        run_load(32'h0000_2002, 2'b01, 1'b0, 32'hAAAA_8001, 5, 10);
        n_cmp++; if (obs_data !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_data: got %h want ffff8001", obs_data); end
        n_cmp++; if (obs_stall !== 6) begin n_bad++; $display("FAIL lh_stall_cycles: got %0d want 6", obs_stall); end
        n_cmp++; if (obs_req !== 5) begin n_bad++; $display("FAIL lh_req_cycles: got %0d want 5", obs_req); end
        n_cmp++; if (obs_mem_addr !== 32'h0000_2000) begin n_bad++; $display("FAIL lh_memaddr: got %h want 00002000", obs_mem_addr); end
    endtask

    task automatic test_lhu();
        run_load(32'h0000_2002, 2'b01, 1'b1, 32'hAAAA_8001, 5, 10);
        n_cmp++; if (obs_data !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu_data: got %h want 00008001", obs_data); end
    endtask

    task automatic test_lw();
        run_load(32'h0000_0004, 2'b10, 1'b1, 32'hDEAD_BEEF, 1, 6);
        n_cmp++; if (obs_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_data: got %h want deadbeef", obs_data); end
        n_cmp++; if (obs_mem_addr !== 32'h0000_0004) begin n_bad++; $display("FAIL lw_memaddr: got %h want 00000004", obs_mem_addr); end
        n_cmp++; if (obs_stall !== 2) begin n_bad++; $display("FAIL lw_stall_cycles: got %0d want 2", obs_stall); end
    endtask

    task automatic test_lanes();
        run_load(32'h0000_1000, 2'b00, 1'b0, 32'h1234_5680, 1, 5);
        n_cmp++; if (obs_data !== 32'h0000_0012) begin n_bad++; $display("FAIL lane_b0: got %h want 00000012", obs_data); end
        run_load(32'h0000_1001, 2'b00, 1'b1, 32'h12F4_5680, 2, 6);
        n_cmp++; if (obs_data !== 32'h0000_00F4) begin n_bad++; $display("FAIL lane_b1u: got %h want 000000f4", obs_data); end
        run_load(32'h0000_1002, 2'b00, 1'b0, 32'h12F4_A680, 1, 5);
        n_cmp++; if (obs_data !== 32'hFFFF_FFA6) begin n_bad++; $display("FAIL lane_b2: got %h want ffffffa6", obs_data); end
        run_load(32'h0000_2000, 2'b01, 1'b0, 32'hAAAA_8001, 1, 5);
        n_cmp++; if (obs_data !== 32'hFFFF_AAAA) begin n_bad++; $display("FAIL lane_h0: got %h want ffffaaaa", obs_data); end
        run_load(32'h0000_2000, 2'b01, 1'b0, 32'h7AAA_8001, 1, 5);
        n_cmp++; if (obs_data !== 32'h0000_7AAA) begin n_bad++; $display("FAIL lane_h0_pos: got %h want 00007aaa", obs_data); end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [3] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0000};
        logic [1:0]  sizes [3] = '{2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 3; i++) begin
            run_load(addrs[i], sizes[i], 1'b0, 32'h5555_5555, 1, 5);
            n_cmp++; if (obs_mis !== 1) begin n_bad++; $display("FAIL mis_pulse[%0d]: got %0d want 1", i, obs_mis); end
            n_cmp++; if (obs_req !== 0 || obs_valid !== 0 || obs_berr !== 0) begin
                n_bad++; $display("FAIL mis_side[%0d]: got req %0d valid %0d berr %0d want 0 0 0", i, obs_req, obs_valid, obs_berr); end
            n_cmp++; if (obs_stall !== 1) begin n_bad++; $display("FAIL mis_stall[%0d]: got %0d want 1", i, obs_stall); end
        end
    endtask

    task automatic test_bus_err();
        run_load(32'h0000_0040, 2'b10, 1'b0, 32'h0BAD_F00D, 1, 5);
        run_load(32'h0000_0080, 2'b10, 1'b0, 32'h1111_2222, 0, MAX_WAIT + 8);
        n_cmp++; if (obs_berr !== 1) begin n_bad++; $display("FAIL berr_pulse: got %0d want 1", obs_berr); end
        n_cmp++; if (obs_req !== MAX_WAIT) begin n_bad++; $display("FAIL berr_req_cycles: got %0d want %0d", obs_req, MAX_WAIT); end
        n_cmp++; if (obs_stall !== MAX_WAIT + 1) begin n_bad++; $display("FAIL berr_stall: got %0d want %0d", obs_stall, MAX_WAIT + 1); end
        n_cmp++; if (obs_valid !== 0 || obs_mis !== 0) begin
            n_bad++; $display("FAIL berr_side: got valid %0d mis %0d want 0 0", obs_valid, obs_mis); end
        n_cmp++; if (LoadData !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL berr_data_kept: got %h want 0badf00d", LoadData); end
        run_load(32'h0000_0044, 2'b10, 1'b0, 32'h3333_4444, 1, 5);
        n_cmp++; if (obs_data !== 32'h3333_4444) begin n_bad++; $display("FAIL berr_recover: got %h want 33334444", obs_data); end
    endtask

    task automatic test_back_to_back();
        int          valids = 0;
        logic        switched = 1'b0;
        logic [31:0] first_data = 'x;
        logic [31:0] second_data = 'x;
        LoadAddr = 32'h0000_1003; LoadSize = 2'b00; LoadUnsigned = 1'b0;
        MemRData = 32'h1234_5680; LoadReq = 1'b1; MemReady = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c == 3) begin
                n_cmp++; if (MemReq !== 1'b0 || Stall !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_idle_gap: got req %b stall %b want 0 1", MemReq, Stall); end
            end
            if (LoadValid) begin
                valids++;
                if (valids == 1) first_data = LoadData;
                else second_data = LoadData;
            end
            MemReady = MemReq;
            if (!Stall) begin
                if (!switched) begin
                    switched = 1'b1;
                    LoadAddr = 32'h0000_2002; LoadSize = 2'b01; LoadUnsigned = 1'b1;
                    MemRData = 32'hAAAA_8001;
                end else begin
                    LoadReq = 1'b0;
                end
            end
            @(negedge Clk);
        end
        MemReady = 1'b0;
        LoadReq  = 1'b0;
        n_cmp++; if (valids !== 2) begin n_bad++; $display("FAIL b2b_valid_count: got %0d want 2", valids); end
        n_cmp++; if (first_data !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL b2b_first: got %h want ffffff80", first_data); end
        n_cmp++; if (second_data !== 32'h0000_8001) begin n_bad++; $display("FAIL b2b_second: got %h want 00008001", second_data); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_lb();
        test_lbu();
        test_lh_slow();
        test_lhu();
        test_lw();
        test_lanes();
        test_misaligned();
        test_bus_err();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
